// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: serves one load or store at a time after
// LATENCY wait states, returning load data with a one-cycle ld strobe.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [31:0]           mem_loca,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld,
   output logic                  done,
   output logic                  busy,
   output logic                  addr_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                  state, state_n;
   logic [3:0]              cnt, cnt_n;
   logic                    we_q;
   logic [31:0]             addr_q;
   logic [DATA_WIDTH-1:0]   st_q;
   logic                    capture, access, in_range;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

   assign in_range = (addr_q >> ADDR_WIDTH) == 32'd0;
   assign idx      = addr_q[ADDR_WIDTH-1:0];

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      capture = 1'b0;
      access  = 1'b0;
      case (state)
         IDLE: if (req) begin
            capture = 1'b1;
            cnt_n   = CNT_INIT;
            state_n = WAIT;
         end
         WAIT: if (cnt == 4'd0) begin
            access  = 1'b1;
            state_n = RESP;
         end else begin
            cnt_n = cnt - 4'd1;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // request fields are frozen for the whole transaction; req in WAIT/RESP never reaches here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= 32'd0;
         st_q   <= '0;
      end else if (capture) begin
         we_q   <= we;
         addr_q <= mem_loca;
         st_q   <= st_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_data  <= '0;
         ld       <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         ld       <= access && !we_q;
         addr_err <= access && !in_range;
         if (access && !we_q)
            ld_data <= in_range ? mem[idx] : '0;
      end
   end

   // RAM has no reset; a store aborted by rst in WAIT never reaches the access edge
   always_ff @(posedge clk) begin
      if (!rst && access && we_q && in_range)
         mem[idx] <= st_q;
   end

   assign done = (state == RESP);
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_data_mem_responder;

   localparam int LAT = 2;

   typedef struct {
      logic        is_ld;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] mem_loca = 32'd0, st_data = 32'd0;
   logic [31:0] ld_data;
   logic        ld, done, busy, addr_err;

   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] mem_loca1 = 32'd0, st_data1 = 32'd0;
   logic [31:0] ld_data1;
   logic        ld1, done1, busy1, addr_err1;

   int vectors = 0;
   int miscompares = 0;

   exp_t        sb[$];
   logic [31:0] model_mem [int];
   logic [31:0] model_ld;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .mem_loca(mem_loca), .st_data(st_data),
      .ld_data(ld_data), .ld(ld), .done(done), .busy(busy), .addr_err(addr_err));

   data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .we(we1), .mem_loca(mem_loca1), .st_data(st_data1),
      .ld_data(ld_data1), .ld(ld1), .done(done1), .busy(busy1), .addr_err(addr_err1));

   // scoreboard: every done pops one expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected_done: done=1 with no request outstanding");
         end else begin
            e = sb.pop_front();
            if (ld !== e.is_ld || addr_err !== e.err || ld_data !== e.data) begin
               miscompares++;
               $display("FAIL sb_resp: got ld=%b err=%b data=%h, want ld=%b err=%b data=%h",
                        ld, addr_err, ld_data, e.is_ld, e.err, e.data);
            end
         end
      end
   end

   // Called at a negedge; returns at a negedge in the first IDLE cycle after the response,
   // so back-to-back calls give the minimum LAT+2 spacing.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic mid);
      exp_t e;
      logic in_r;
      in_r = (a >> 8) == 32'd0;
      e.is_ld = !w;
      e.err   = !in_r;
      if (w) begin
         if (in_r) model_mem[int'(a)] = d;
      end else begin
         model_ld = (in_r && model_mem.exists(int'(a))) ? model_mem[int'(a)] : 32'd0;
      end
      e.data = model_ld;
      sb.push_back(e);
      req = 1'b1; we = w; mem_loca = a; st_data = d;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      for (int c = 1; c <= LAT + 1; c++) begin
         vectors++;
         if (busy !== 1'b1 || done !== (c == LAT + 1)) begin
            miscompares++;
            $display("FAIL req_timing cyc%0d: busy=%b done=%b, want busy=1 done=%b",
                     c, busy, done, (c == LAT + 1));
         end
         if (mid && c == 1) begin
            req = 1'b1; we = 1'b0; mem_loca = 32'd9;
         end else if (mid) begin
            req = 1'b0;
         end
         @(negedge clk);
      end
      req = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || ld !== 1'b0 || addr_err !== 1'b0 || ld_data !== model_ld) begin
         miscompares++;
         $display("FAIL req_idle: busy=%b done=%b ld=%b err=%b data=%h, want 0 0 0 0 %h",
                  busy, done, ld, addr_err, ld_data, model_ld);
      end
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({ld, done, busy, addr_err} !== 4'b0 || ld_data !== 32'd0 ||
          {ld1, done1, busy1, addr_err1} !== 4'b0 || ld_data1 !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: ld=%b done=%b busy=%b err=%b data=%h, want all 0",
                  ld, done, busy, addr_err, ld_data);
      end
      @(negedge clk);
      rst = 1'b0;
      model_ld = 32'd0;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      do_req(1'b1, 32'd4, 32'h1234_5678, 1'b0);
      do_req(1'b0, 32'd4, 32'h0, 1'b0);
      do_req(1'b1, 32'd3, 32'h3333_3333, 1'b0);
      do_req(1'b1, 32'd7, 32'h1111_1111, 1'b0);
      do_req(1'b1, 32'd255, 32'h0BAD_F00D, 1'b0);
      do_req(1'b0, 32'd255, 32'h0, 1'b0);
   endtask

   task automatic test_busy_ignore();
      do_req(1'b0, 32'd4, 32'h0, 1'b0);
      do_req(1'b1, 32'd9, 32'hDEAD_BEEF, 1'b1);
      vectors++;
      if (ld_data !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL hold_ld_data: got %h, want %h", ld_data, 32'h1234_5678);
      end
      do_req(1'b0, 32'd9, 32'h0, 1'b0);
   endtask

   task automatic test_out_of_range();
      do_req(1'b0, 32'h0000_0100, 32'h0, 1'b0);
      do_req(1'b1, 32'h0000_0103, 32'hFFFF_FFFF, 1'b0);
      do_req(1'b0, 32'd3, 32'h0, 1'b0);
      do_req(1'b0, 32'h8000_0004, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid_store();
      req = 1'b1; we = 1'b1; mem_loca = 32'd7; st_data = 32'hAAAA_5555;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if ({ld, done, busy, addr_err} !== 4'b0 || ld_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_mid: ld=%b done=%b busy=%b err=%b data=%h, want all 0",
                  ld, done, busy, addr_err, ld_data);
      end
      @(negedge clk);
      rst = 1'b0;
      model_ld = 32'd0;
      repeat (3) @(negedge clk);
      do_req(1'b0, 32'd7, 32'h0, 1'b0);
   endtask

   task automatic test_latency1();
      req1 = 1'b1; we1 = 1'b1; mem_loca1 = 32'd5; st_data1 = 32'h5A5A_0001;
      @(posedge clk);
      @(negedge clk);
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      req1 = 1'b1; we1 = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         vectors++;
         if (busy1 !== (c % 3 != 0) || done1 !== (c % 3 == 2) || ld1 !== (c % 3 == 2) ||
             (c % 3 == 2 && ld_data1 !== 32'h5A5A_0001)) begin
            miscompares++;
            $display("FAIL lat1 cyc%0d: busy=%b done=%b ld=%b data=%h, want busy=%b done=%b data=5a5a0001",
                     c, busy1, done1, ld1, ld_data1, (c % 3 != 0), (c % 3 == 2));
         end
      end
      req1 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_busy_ignore();
      test_out_of_range();
      test_reset_mid_store();
      test_latency1();
      repeat (4) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d responses missing, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
